// File: rtl/rr_mux_pkg.sv
// Shared types and helpers for the 8-source round-robin mux arbiter.
// RR_MUX_PRIO_EN (see rr_mux_arbiter_8) does not change anything in this package.
package rr_mux_pkg;

  localparam int N_SRC = 8;
  localparam int SEL_W = 3;

  typedef logic [SEL_W-1:0] sel_t;
  typedef logic [N_SRC-1:0] vec_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  // One-hot vector with only bit idx set; rotating a single 1 by idx.
  function automatic vec_t rotate_onehot(input sel_t idx);
    vec_t base;
    base = vec_t'(1);
    return base << idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of req searching last+1, last+2, ... mod 8.
module rr_pick
  import rr_mux_pkg::*;
(
  input  logic [N_SRC-1:0] req,
  input  sel_t             last,
  output logic             any,
  output sel_t             win
);

  logic [N_SRC-1:0] rot;
  sel_t             off;

  // rot[k] is the requester k+1 places after the last winner; sel_t arithmetic wraps 7 -> 0.
  generate
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_rot
      sel_t src_idx;
      assign src_idx = last + sel_t'(gi) + sel_t'(1);
      assign rot[gi] = req[src_idx];
    end
  endgenerate

  always_comb begin
    off = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (rot[i]) off = sel_t'(i);
    end
  end

  assign any = |req;
  assign win = last + off + sel_t'(1);

endmodule

// File: rtl/rr_mux_arbiter_8.sv
// Round-robin 8:1 mux controller with a single registered output beat.
// Define RR_MUX_PRIO_EN to add prio_mask: masked requesters are arbitrated ahead of the rest.
module rr_mux_arbiter_8
  import rr_mux_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_SRC-1:0]        req_valid,
  input  logic [N_SRC*DATA_W-1:0] req_data,
  output logic [N_SRC-1:0]        req_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       out_data,
  output sel_t                    out_src
`ifdef RR_MUX_PRIO_EN
  ,
  input  logic [N_SRC-1:0]        prio_mask
`endif
);

  state_t            state_reg;
  logic [DATA_W-1:0] data_reg;
  sel_t              src_reg;
  sel_t              last_reg;

  logic              load;
  logic              any;
  sel_t              win;
  logic              grant;
  logic [DATA_W-1:0] data_arr [N_SRC];

  generate
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_slice
      assign data_arr[gi] = req_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

`ifdef RR_MUX_PRIO_EN
  logic hi_any;
  logic lo_any;
  sel_t hi_win;
  sel_t lo_win;

  rr_pick u_pick_hi (
    .req  (req_valid & prio_mask),
    .last (last_reg),
    .any  (hi_any),
    .win  (hi_win)
  );

  rr_pick u_pick_lo (
    .req  (req_valid),
    .last (last_reg),
    .any  (lo_any),
    .win  (lo_win)
  );

  assign any = hi_any | lo_any;
  assign win = hi_any ? hi_win : lo_win;
`else
  rr_pick u_pick (
    .req  (req_valid),
    .last (last_reg),
    .any  (any),
    .win  (win)
  );
`endif

  assign load  = (state_reg == EMPTY) || out_ready;
  // Gated by rst_n so no producer sees its beat consumed while the block is held in reset.
  assign grant = rst_n && load && any;

  assign req_ready = grant ? rotate_onehot(win) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= EMPTY;
      data_reg  <= '0;
      src_reg   <= '0;
      last_reg  <= sel_t'(N_SRC - 1);
    end else if (load) begin
      if (any) begin
        state_reg <= FULL;
        data_reg  <= data_arr[win];
        src_reg   <= win;
        last_reg  <= win;
      end else begin
        state_reg <= EMPTY;
      end
    end
  end

  assign out_valid = (state_reg == FULL);
  assign out_data  = data_reg;
  assign out_src   = src_reg;

endmodule

// File: tb/tb_rr_mux_arbiter_8.sv
// Directed self-checking bench for rr_mux_arbiter_8; priority scenario runs when RR_MUX_PRIO_EN is defined.
module tb_rr_mux_arbiter_8;
  import rr_mux_pkg::*;

  localparam int DATA_W = 8;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [N_SRC-1:0]        req_valid;
  logic [N_SRC*DATA_W-1:0] req_data;
  logic [N_SRC-1:0]        req_ready;
  logic                    out_valid;
  logic                    out_ready;
  logic [DATA_W-1:0]       out_data;
  sel_t                    out_src;
  logic [N_SRC-1:0]        prio_mask;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rr_mux_arbiter_8 #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_src   (out_src)
`ifdef RR_MUX_PRIO_EN
    ,
    .prio_mask (prio_mask)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input logic [7:0] base);
    for (int i = 0; i < N_SRC; i++) req_data[i*DATA_W +: DATA_W] = base + 8'(i);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    out_ready = 1'b0;
    prio_mask = '0;
    req_data  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    prio_mask = '0;
    set_data(8'h55);
    req_valid = 8'hFF;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_src !== 3'd0) begin
      errors++;
      $display("FAIL reset_regs: got valid=%b data=%h src=%0d expected 0/00/0", out_valid, out_data, out_src);
    end
    checks++;
    if (req_ready !== 8'h00) begin
      errors++;
      $display("FAIL reset_ready: got %h expected 00", req_ready);
    end
    req_valid = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (req_ready !== 8'h00) begin
        errors++;
        $display("FAIL idle_ready[%0d]: got %h expected 00", c, req_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL idle_valid[%0d]: got %b expected 0", c, out_valid);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_ready;
    do_reset();
    set_data(8'h10);
    req_valid = 8'hFF;
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      #1;
      exp_ready = 8'h01 << (i % 8);
      checks++;
      if (req_ready !== exp_ready) begin
        errors++;
        $display("FAIL rr_ready[%0d]: got %h expected %h", i, req_ready, exp_ready);
      end
      tick();
      $display("rr beat %0d: src=%0d data=%h", i, out_src, out_data);
      checks++;
      if (out_valid !== 1'b1 || out_src !== sel_t'(i % 8) || out_data !== 8'h10 + 8'(i % 8)) begin
        errors++;
        $display("FAIL rr_beat[%0d]: got valid=%b src=%0d data=%h expected 1/%0d/%h",
                 i, out_valid, out_src, out_data, i % 8, 8'h10 + 8'(i % 8));
      end
    end
  endtask

  task automatic test_alternate();
    sel_t exp_seq [4];
    exp_seq = '{3'd0, 3'd7, 3'd0, 3'd7};
    do_reset();
    set_data(8'hB0);
    req_valid = 8'b1000_0001;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      $display("alt beat %0d: src=%0d data=%h", i, out_src, out_data);
      checks++;
      if (out_src !== exp_seq[i] || out_data !== 8'hB0 + 8'(exp_seq[i])) begin
        errors++;
        $display("FAIL alt_beat[%0d]: got src=%0d data=%h expected %0d/%h",
                 i, out_src, out_data, exp_seq[i], 8'hB0 + 8'(exp_seq[i]));
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    set_data(8'h40);
    req_valid = 8'h04;
    out_ready = 1'b0;
    #1;
    checks++;
    if (req_ready !== 8'h04) begin
      errors++;
      $display("FAIL bp_first_ready: got %h expected 04", req_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_src !== 3'd2 || out_data !== 8'h42) begin
      errors++;
      $display("FAIL bp_first_beat: got %b/%0d/%h expected 1/2/42", out_valid, out_src, out_data);
    end
    req_data[2*DATA_W +: DATA_W] = 8'hA5;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++;
      if (req_ready !== 8'h00) begin
        errors++;
        $display("FAIL bp_hold_ready[%0d]: got %h expected 00", c, req_ready);
      end
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_src !== 3'd2 || out_data !== 8'h42) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got %b/%0d/%h expected 1/2/42", c, out_valid, out_src, out_data);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 8'h04) begin
      errors++;
      $display("FAIL bp_release_ready: got %h expected 04", req_ready);
    end
    tick();
    $display("bp beat: src=%0d data=%h", out_src, out_data);
    checks++;
    if (out_valid !== 1'b1 || out_src !== 3'd2 || out_data !== 8'hA5) begin
      errors++;
      $display("FAIL bp_next_beat: got %b/%0d/%h expected 1/2/a5", out_valid, out_src, out_data);
    end
    req_valid = 8'h00;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: got %b expected 0", out_valid);
    end
  endtask

  task automatic test_skip();
    do_reset();
    set_data(8'h20);
    req_valid = 8'hFF;
    out_ready = 1'b1;
    tick();
    req_valid = 8'b0000_1100;
    #1;
    checks++;
    if (req_ready !== 8'h04) begin
      errors++;
      $display("FAIL skip_ready: got %h expected 04", req_ready);
    end
    tick();
    checks++;
    if (out_src !== 3'd2 || out_data !== 8'h22) begin
      errors++;
      $display("FAIL skip_beat: got %0d/%h expected 2/22", out_src, out_data);
    end
    req_valid = 8'h41;
    #1;
    checks++;
    if (req_ready !== 8'h40) begin
      errors++;
      $display("FAIL skip_ready2: got %h expected 40", req_ready);
    end
    tick();
    checks++;
    if (out_src !== 3'd6 || out_data !== 8'h26) begin
      errors++;
      $display("FAIL skip_beat2: got %0d/%h expected 6/26", out_src, out_data);
    end
    tick();
    checks++;
    if (out_src !== 3'd0 || out_data !== 8'h20) begin
      errors++;
      $display("FAIL skip_wrap: got %0d/%h expected 0/20", out_src, out_data);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    set_data(8'h60);
    req_valid = 8'h08;
    out_ready = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_src !== 3'd3) begin
      errors++;
      $display("FAIL mr_full: got %b/%0d expected 1/3", out_valid, out_src);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_src !== 3'd0 || req_ready !== 8'h00) begin
      errors++;
      $display("FAIL mr_async: got valid=%b data=%h src=%0d ready=%h expected 0/00/0/00",
               out_valid, out_data, out_src, req_ready);
    end
    req_valid = 8'h81;
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (req_ready !== 8'h01) begin
      errors++;
      $display("FAIL mr_first_ready: got %h expected 01", req_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_src !== 3'd0 || out_data !== 8'h60) begin
      errors++;
      $display("FAIL mr_first_beat: got %b/%0d/%h expected 1/0/60", out_valid, out_src, out_data);
    end
  endtask

`ifdef RR_MUX_PRIO_EN
  task automatic test_prio();
    do_reset();
    set_data(8'hC0);
    req_valid = 8'hFF;
    out_ready = 1'b1;
    prio_mask = 8'h20;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out_src !== 3'd5 || out_data !== 8'hC5) begin
        errors++;
        $display("FAIL prio_beat[%0d]: got %0d/%h expected 5/c5", i, out_src, out_data);
      end
    end
    prio_mask = 8'h00;
    tick();
    checks++;
    if (out_src !== 3'd6) begin
      errors++;
      $display("FAIL prio_resume: got %0d expected 6", out_src);
    end
    tick();
    checks++;
    if (out_src !== 3'd7) begin
      errors++;
      $display("FAIL prio_resume2: got %0d expected 7", out_src);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_alternate();
    test_backpressure();
    test_skip();
    test_mid_reset();
`ifdef RR_MUX_PRIO_EN
    test_prio();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
